mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single memory port of the multicycle MIPS system between the processor (requester 0) and a DMA/loader engine (requester 1). It serialises accesses through a request/ack handshake, owns the memory-side `adr`, `writedata` and `memwrite`, counts out a configurable read latency, and returns the read word to the winner. It sits between the processor top and the unified instruction/data memory; the processor stalls on its `c_req` until `c_ack`.

## Interface
- `MEM_LAT`, default 1: memory read latency in cycles. Legal range 0..15.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `c_req` in 1: processor access request. Held high until `c_ack`.
- `c_we` in 1: processor write (1) or read (0).
- `c_adr` in 32: processor byte address.
- `c_wdata` in 32: processor write data.
- `c_ack` out 1: one-cycle completion pulse to the processor.
- `d_req`, `d_we`, `d_adr[31:0]`, `d_wdata[31:0]` in: same meanings for the DMA/loader.
- `d_ack` out 1: one-cycle completion pulse to the DMA/loader.
- `rdata` out 32: captured read word. Valid in the ack cycle and held until the next capture.
- `owner` out 1: requester currently granted (0 = processor, 1 = DMA). Meaningful while `busy`.
- `busy` out 1: high in the BUSY and DONE states.
- `adr` out 32: memory address.
- `writedata` out 32: memory write data.
- `memwrite` out 1: memory write strobe.
- `readdata` in 32: memory read data.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE**
  - If no `req` is high, stay in IDLE.
  - Otherwise pick a winner. Register the winner's `adr`, `we` and `wdata`, set `owner`, load `cnt = MEM_LAT`, and go to BUSY.
- **BUSY**
  - `adr` and `writedata` are driven from the registered values.
  - `memwrite` = registered `we` only in the first BUSY cycle. Exactly one write pulse per access.
  - If `cnt == 0`: capture `readdata` into `rdata` (reads only; on writes `rdata` is unchanged) and go to DONE.
  - Otherwise decrement `cnt`.
- **DONE**
  - Assert `c_ack` or `d_ack` per `owner` for exactly one cycle.
  - Update the round-robin pointer (see Configuration).
  - Go to IDLE.
- Requester inputs are sampled only in IDLE. Changes to `adr`, `we` or `wdata` after the grant are ignored.
- If `req` is still high in the IDLE cycle after its ack, that is a new request (back-to-back streaming).
- `cnt` is 4 bits. There is no wrap, because it only decrements from `MEM_LAT` to 0.
- The `adr` and `writedata` registers hold their last values in IDLE and DONE. `memwrite` is 0 outside the first BUSY cycle.
- **Reset:**
  - All outputs are reset to 0: `c_ack`, `d_ack`, `rdata`, `owner`, `busy`, `adr`, `writedata`, `memwrite`.
  - `cnt` is reset to 0. The round-robin pointer is reset to 1.
- **Reset mid-operation:** the FSM goes to IDLE the next cycle and no ack is issued. A write whose `memwrite` pulse already fired is considered performed. The requester must reissue after reset.

## Timing
- A request seen in IDLE at cycle 0 produces the ack at cycle `MEM_LAT + 2`:
  - cycle 0: grant
  - cycles 1 .. `1 + MEM_LAT`: BUSY
  - cycle `MEM_LAT + 2`: DONE
- Minimum access period per requester is `MEM_LAT + 3` cycles (includes the IDLE re-arbitration cycle).
- `memwrite` is high in cycle 1 only.
- `readdata` is sampled at the clock edge that ends BUSY cycle `1 + MEM_LAT`.
- `rdata` is registered and stable from the ack cycle onward.
- Both requests high in IDLE: exactly one grant. The loser keeps `req` high and is granted in the next IDLE cycle.
- No combinational paths from `req` to `ack`, or from `readdata` to `rdata`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer `last` holds the most recently served requester and is updated in DONE.
  - On a tie, grant `!last`. Reset value of `last` is 1, so the processor wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority. The processor (`c_req`) always wins ties. The pointer logic is absent.
- The single-requester case is identical in both builds.

## Test plan
- **Processor read, `MEM_LAT`=1**
  - Stimulus: `c_req`=1, `c_we`=0, `c_adr`=0x0000_0010. Memory returns 0xDEAD_BEEF.
  - Required: `adr`=0x10 from cycle 1; `c_ack` in cycle 3 only; `rdata`=0xDEAD_BEEF; `d_ack` never high.
- **DMA write, `MEM_LAT`=3**
  - Stimulus: `d_adr`=0x100, `d_wdata`=0x1234_5678, `d_we`=1.
  - Required: `memwrite` high exactly 1 cycle (cycle 1) with `adr`=0x100 and `writedata`=0x1234_5678; `d_ack` in cycle 5; `rdata` unchanged.
- **Simultaneous requests, both held, `MEM_LAT`=0**
  - With `MEM_ARB_RR_EN`: grant order is processor, DMA, processor, DMA; acks at cycles 2, 5, 8, 11.
  - Without `MEM_ARB_RR_EN`: the processor is granted every time while `c_req` stays high.
- **Back-to-back processor reads**
  - Stimulus: `c_req` held high across the ack, address changed in the ack cycle.
  - Required: second grant in the following IDLE cycle uses the new address; second ack arrives `MEM_LAT + 3` cycles after the first.
- **Reset mid-BUSY**
  - Stimulus: `reset` asserted in cycle 2 of a `MEM_LAT`=3 read.
  - Required: next cycle IDLE, `busy`=0, all outputs 0, no ack; a re-issued request completes normally.
- **Latency sweep**
  - Stimulus: `MEM_LAT` = 0, 1, 7, 15.
  - Required: ack at exactly `MEM_LAT + 2`; `readdata` sampled only at the last BUSY cycle (bench changes `readdata` every cycle to prove it).

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the memory port and mem_arbiter.
// The arbiter attaches through the slave modport; the requester/memory side
// (processor top, DMA engine, memory, or a bench) uses the master modport.
interface mem_arbiter_if;
    // Processor (requester 0)
    logic        c_req;
    logic        c_we;
    logic [31:0] c_adr;
    logic [31:0] c_wdata;
    logic        c_ack;
    // DMA / loader (requester 1)
    logic        d_req;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic        d_ack;
    // Shared return path and status
    logic [31:0] rdata;
    logic        owner;
    logic        busy;
    // Memory port
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;

    modport slave (
        input  c_req, c_we, c_adr, c_wdata,
        input  d_req, d_we, d_adr, d_wdata,
        input  readdata,
        output c_ack, d_ack, rdata, owner, busy,
        output adr, writedata, memwrite
    );

    modport master (
        output c_req, c_we, c_adr, c_wdata,
        output d_req, d_we, d_adr, d_wdata,
        output readdata,
        input  c_ack, d_ack, rdata, owner, busy,
        input  adr, writedata, memwrite
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port of the multicycle MIPS system
// between the processor (requester 0) and a DMA/loader (requester 1).
// One access at a time: IDLE -> BUSY (MEM_LAT+1 cycles) -> DONE (ack) -> IDLE.
// Optional build macro MEM_ARB_RR_EN: round-robin tie breaking using a
// one-bit "last served" pointer. Without it the processor wins every tie.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Latency counter is 4 bits wide; legal MEM_LAT is 0..15.
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] adr_q,   adr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q,    we_d;
    logic        owner_q, owner_d;
    logic        first_q, first_d;
    logic [31:0] rdata_q, rdata_d;
    logic        grant_dma;

`ifdef MEM_ARB_RR_EN
    logic        last_q, last_d;

    // Tie goes to whoever was not served last; a lone requester always wins.
    assign grant_dma = bus.d_req & (~bus.c_req | ~last_q);
`else
    // Fixed priority: the processor wins every tie.
    assign grant_dma = bus.d_req & ~bus.c_req;
`endif

    // Next-state logic for the access FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        owner_d = owner_q;
        first_d = 1'b0;
        rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Requester inputs are only looked at here; later changes are ignored.
                if (bus.c_req || bus.d_req) begin
                    owner_d = grant_dma;
                    adr_d   = grant_dma ? bus.d_adr   : bus.c_adr;
                    wdata_d = grant_dma ? bus.d_wdata : bus.c_wdata;
                    we_d    = grant_dma ? bus.d_we    : bus.c_we;
                    cnt_d   = LAT_INIT;
                    first_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    // Last BUSY cycle: the memory word is valid now.
                    if (!we_q) begin
                        rdata_d = bus.readdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
`ifdef MEM_ARB_RR_EN
                last_d  = owner_q;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears every visible output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            owner_q <= 1'b0;
            first_q <= 1'b0;
            rdata_q <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            owner_q <= owner_d;
            first_q <= first_d;
            rdata_q <= rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Outputs are decoded from registers only: no req->ack or readdata->rdata path.
    assign bus.c_ack     = (state_q == ST_DONE) & ~owner_q;
    assign bus.d_ack     = (state_q == ST_DONE) &  owner_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.owner     = owner_q;
    assign bus.rdata     = rdata_q;
    assign bus.adr       = adr_q;
    assign bus.writedata = wdata_q;
    // One write strobe per access, in the first BUSY cycle only.
    assign bus.memwrite  = (state_q == ST_BUSY) & first_q & we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: five instances with MEM_LAT = 0, 1, 3, 7, 15
// share one clock; each has its own reset bit. Inputs are driven and outputs
// sampled 1 ns after the rising edge.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic [4:0] rst;
    int         n_chk = 0;
    int         n_err = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter_if if0 ();
    mem_arbiter_if if1 ();
    mem_arbiter_if if3 ();
    mem_arbiter_if if7 ();
    mem_arbiter_if if15 ();

    mem_arbiter #(.MEM_LAT(0))  u_l0  (.clk(clk), .reset(rst[0]), .bus(if0));
    mem_arbiter #(.MEM_LAT(1))  u_l1  (.clk(clk), .reset(rst[1]), .bus(if1));
    mem_arbiter #(.MEM_LAT(3))  u_l3  (.clk(clk), .reset(rst[2]), .bus(if3));
    mem_arbiter #(.MEM_LAT(7))  u_l7  (.clk(clk), .reset(rst[3]), .bus(if7));
    mem_arbiter #(.MEM_LAT(15)) u_l15 (.clk(clk), .reset(rst[4]), .bus(if15));

    virtual mem_arbiter_if vl0, vl1, vl3, vl7, vl15;
    logic [31:0] e0, e1, e3, e7, e15;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_if(input virtual mem_arbiter_if v);
        v.c_req = 1'b0; v.c_we = 1'b0; v.c_adr = 32'd0; v.c_wdata = 32'd0;
        v.d_req = 1'b0; v.d_we = 1'b0; v.d_adr = 32'd0; v.d_wdata = 32'd0;
        v.readdata = 32'd0;
    endtask

    task automatic check_zero(input virtual mem_arbiter_if v, input string tag);
        chk({tag, ".c_ack"},     32'(v.c_ack),    32'd0);
        chk({tag, ".d_ack"},     32'(v.d_ack),    32'd0);
        chk({tag, ".rdata"},     v.rdata,         32'd0);
        chk({tag, ".owner"},     32'(v.owner),    32'd0);
        chk({tag, ".busy"},      32'(v.busy),     32'd0);
        chk({tag, ".adr"},       v.adr,           32'd0);
        chk({tag, ".writedata"}, v.writedata,     32'd0);
        chk({tag, ".memwrite"},  32'(v.memwrite), 32'd0);
    endtask

    // One isolated access starting from IDLE at cycle 0. readdata is either
    // constant (rd_base) or rd_base + cycle number, so the captured value
    // reveals exactly which cycle was sampled.
    task automatic single_access(input virtual mem_arbiter_if v, input int lat,
                                 input bit dma, input bit we,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd_base, input bit vary,
                                 inout logic [31:0] exp_rd, input string tag);
        logic [31:0] old_rd;
        old_rd = exp_rd;
        if (dma) begin
            v.d_req = 1'b1; v.d_we = we; v.d_adr = a; v.d_wdata = wd;
        end else begin
            v.c_req = 1'b1; v.c_we = we; v.c_adr = a; v.c_wdata = wd;
        end
        v.readdata = rd_base;
        chk({tag, ".idle0"}, 32'(v.busy), 32'd0);
        for (int k = 1; k <= lat + 2; k++) begin
            tick();
            v.readdata = vary ? rd_base + 32'(k) : rd_base;
            if (k == 1) begin
                if (dma) begin
                    v.d_adr = ~a; v.d_wdata = ~wd; v.d_we = ~we;
                end else begin
                    v.c_adr = ~a; v.c_wdata = ~wd; v.c_we = ~we;
                end
            end
            chk({tag, ".busy"},      32'(v.busy),     32'd1);
            chk({tag, ".adr"},       v.adr,           a);
            chk({tag, ".writedata"}, v.writedata,     wd);
            chk({tag, ".owner"},     32'(v.owner),    32'(dma));
            chk({tag, ".memwrite"},  32'(v.memwrite), 32'((k == 1) && we));
            chk({tag, ".c_ack"},     32'(v.c_ack),    32'(!dma && (k == lat + 2)));
            chk({tag, ".d_ack"},     32'(v.d_ack),    32'(dma && (k == lat + 2)));
            if (k < lat + 2) begin
                chk({tag, ".rdata_early"}, v.rdata, old_rd);
            end
        end
        if (!we) begin
            exp_rd = vary ? rd_base + 32'(lat + 1) : rd_base;
        end
        chk({tag, ".rdata"}, v.rdata, exp_rd);
        v.c_req = 1'b0; v.d_req = 1'b0; v.c_we = 1'b0; v.d_we = 1'b0;
        tick();
        chk({tag, ".busy_after"},  32'(v.busy),     32'd0);
        chk({tag, ".c_ack_after"}, 32'(v.c_ack),    32'd0);
        chk({tag, ".d_ack_after"}, 32'(v.d_ack),    32'd0);
        chk({tag, ".mw_after"},    32'(v.memwrite), 32'd0);
        chk({tag, ".adr_hold"},    v.adr,           a);
        chk({tag, ".rdata_hold"},  v.rdata,         exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_c, exp_d, exp_own;
        vl0 = if0; vl1 = if1; vl3 = if3; vl7 = if7; vl15 = if15;
        e0 = 32'd0; e1 = 32'd0; e3 = 32'd0; e7 = 32'd0; e15 = 32'd0;
        init_if(vl0); init_if(vl1); init_if(vl3); init_if(vl7); init_if(vl15);
        rst = 5'h1f;
        tick(); tick(); tick();
        rst = 5'h00;
        tick();
        check_zero(vl0, "rst.l0");
        check_zero(vl1, "rst.l1");
        check_zero(vl3, "rst.l3");
        check_zero(vl7, "rst.l7");
        check_zero(vl15, "rst.l15");

        // Both requesters held, MEM_LAT = 0. The processor drops after its
        // cycle-11 slot so the DMA must be served next in either build.
        vl0.c_req = 1'b1; vl0.c_adr = 32'h20; vl0.c_we = 1'b0;
        vl0.d_req = 1'b1; vl0.d_adr = 32'h40; vl0.d_we = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_c = RR ? (k == 2 || k == 8) : (k == 2 || k == 5 || k == 8 || k == 11);
            exp_d = RR ? (k == 5 || k == 11 || k == 14) : (k == 14);
            chk($sformatf("tie.c_ack@%0d", k), 32'(vl0.c_ack), 32'(exp_c));
            chk($sformatf("tie.d_ack@%0d", k), 32'(vl0.d_ack), 32'(exp_d));
            if (k == 1 || k == 4 || k == 7 || k == 10 || k == 13) begin
                exp_own = (k == 13) ? 1'b1 : (RR ? (k == 4 || k == 10) : 1'b0);
                chk($sformatf("tie.owner@%0d", k), 32'(vl0.owner), 32'(exp_own));
                chk($sformatf("tie.adr@%0d", k), vl0.adr, exp_own ? 32'h40 : 32'h20);
            end
            if (k == 11) vl0.c_req = 1'b0;
            if (k == 14) vl0.d_req = 1'b0;
        end
        tick();
        chk("tie.idle_end", 32'(vl0.busy), 32'd0);

        // Processor read, MEM_LAT = 1, memory returns 0xDEADBEEF.
        single_access(vl1, 1, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, e1, "cread");

        // Back-to-back processor reads on MEM_LAT = 1: acks at cycles 3 and 7.
        vl1.c_req = 1'b1; vl1.c_we = 1'b0; vl1.c_adr = 32'h100; vl1.readdata = 32'h1111_1111;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("b2b.c_ack@%0d", k), 32'(vl1.c_ack), 32'(k == 3 || k == 7));
            chk($sformatf("b2b.busy@%0d", k), 32'(vl1.busy), 32'(k != 4 && k != 8));
            if (k == 1 || k == 2) chk($sformatf("b2b.adr@%0d", k), vl1.adr, 32'h100);
            if (k == 5 || k == 6) chk($sformatf("b2b.adr@%0d", k), vl1.adr, 32'h200);
            if (k == 3) begin
                chk("b2b.rdata1", vl1.rdata, 32'h1111_1111);
                vl1.c_adr = 32'h200;
                vl1.readdata = 32'h2222_2222;
            end
            if (k == 7) begin
                chk("b2b.rdata2", vl1.rdata, 32'h2222_2222);
                vl1.c_req = 1'b0;
            end
        end
        e1 = 32'h2222_2222;

        // MEM_LAT = 3: a read to load rdata, then reset in cycle 2 of a read.
        single_access(vl3, 3, 1'b0, 1'b0, 32'h30, 32'h0, 32'h5555_AAAA, 1'b0, e3, "l3.pre");
        vl3.c_req = 1'b1; vl3.c_we = 1'b0; vl3.c_adr = 32'h300; vl3.readdata = 32'h3333_3333;
        tick();
        chk("rstmid.busy1", 32'(vl3.busy), 32'd1);
        tick();
        chk("rstmid.busy2", 32'(vl3.busy), 32'd1);
        rst[2] = 1'b1;
        vl3.c_req = 1'b0;
        tick();
        check_zero(vl3, "rstmid");
        rst[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rstmid.noack@%0d", k), 32'(vl3.c_ack | vl3.d_ack | vl3.busy), 32'd0);
        end
        e3 = 32'd0;
        single_access(vl3, 3, 1'b0, 1'b0, 32'h304, 32'h0, 32'h7777_0000, 1'b1, e3, "l3.reissue");

        // DMA write, MEM_LAT = 3: one strobe in cycle 1, d_ack in cycle 5, rdata kept.
        single_access(vl3, 3, 1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, e3, "dwrite");
        chk("dwrite.rdata_kept", vl3.rdata, 32'h7777_0004);

        // Latency sweep with readdata changing every cycle.
        single_access(vl0,  0,  1'b0, 1'b0, 32'hA0, 32'h0, 32'hA000_0000, 1'b1, e0,  "sweep0");
        single_access(vl1,  1,  1'b1, 1'b0, 32'hA1, 32'h0, 32'hA100_0000, 1'b1, e1,  "sweep1");
        single_access(vl7,  7,  1'b0, 1'b0, 32'hA7, 32'h0, 32'hA700_0000, 1'b1, e7,  "sweep7");
        single_access(vl15, 15, 1'b1, 1'b0, 32'hAF, 32'h0, 32'hAF00_0000, 1'b1, e15, "sweep15");
        chk("sweep0.value",  e0,  32'hA000_0001);
        chk("sweep15.value", vl15.rdata, 32'hAF00_0010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
